// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr_if
//   Bundle of the stream signals around stream_mux_rr.
//   W : data width per channel
//   N : number of input channels (SW = $clog2(N) bits of channel index)
//   Input side : in_valid[N], in_data[N*W] (channel i at [i*W +: W]), in_ready[N]
//   Output side: out_valid, out_data[W], out_sel[SW], out_ready
//   With STREAM_MUX_PKT_LOCK_EN defined, in_last[N] and out_last are added.
//   Modports:
//     slave  - the multiplexer's view (consumes inputs, drives the output beat)
//     master - the surrounding producers/consumer
interface stream_mux_rr_if #(
  parameter int W = 4,
  parameter int N = 4
);
  localparam int SW = $clog2(N);

  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_ready;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic [N-1:0]   in_last;
  logic           out_last;
`endif

  modport slave (
    input  in_valid, in_data, out_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
    input  in_last,
    output out_last,
`endif
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data, out_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
    output in_last,
    input  out_last,
`endif
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
//   N:1 valid/ready stream multiplexer with round-robin arbitration and a
//   single registered output stage.
//   Parameters: W (data width per channel), N (channels, >= 2).
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset
//     bus   - stream_mux_rr_if.slave: in_valid/in_data/in_ready per channel,
//             registered out_valid/out_data/out_sel with out_ready.
//   Optional feature macro: STREAM_MUX_PKT_LOCK_EN
//     Adds in_last/out_last; once a non-last beat is taken from a channel the
//     arbiter stays on that channel until its last beat has been taken.
module stream_mux_rr #(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  stream_mux_rr_if.slave bus
);
  localparam int SW = $clog2(N);
  localparam logic [SW-1:0] LAST_CH = SW'(N - 1);

  logic          load;
  logic          any_gnt;
  logic [SW-1:0] gnt;
  logic [SW-1:0] ptr_nxt;
  logic [N-1:0]  elig;
  logic [W-1:0]  gnt_data;
  logic [SW:0]   idx;

  logic          vld_p0;
  logic [W-1:0]  data_p0;
  logic [SW-1:0] sel_p0;
  logic [SW-1:0] ptr;

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic          lock_act;
  logic [SW-1:0] lock_ch;
  logic          last_p0;
  logic          gnt_last;
`endif

  // ---- Stage p0 input side: arbitration and input handshake ----
  // The output register can take a new beat when empty or being drained.
  assign load = !vld_p0 || bus.out_ready;

  always_comb begin
    elig = bus.in_valid;
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (lock_act) begin
      elig          = '0;
      elig[lock_ch] = bus.in_valid[lock_ch];
    end
`endif
  end

  // Scan from the farthest offset down to offset 0 so the channel nearest
  // to ptr (in ptr, ptr+1, ... order, modulo N) is the one left in gnt.
  always_comb begin
    any_gnt = 1'b0;
    gnt     = '0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (SW+1)'(k);
      if (idx >= (SW+1)'(N)) idx = idx - (SW+1)'(N);
      if (elig[idx[SW-1:0]]) begin
        any_gnt = 1'b1;
        gnt     = idx[SW-1:0];
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt == SW'(i)) gnt_data = bus.in_data[i*W +: W];
    end
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  assign gnt_last = bus.in_last[gnt];
`endif

  assign ptr_nxt = (gnt == LAST_CH) ? '0 : gnt + 1'b1;

  // rst_n gating keeps every ready low while reset is held.
  always_comb begin
    bus.in_ready = '0;
    if (rst_n && load && any_gnt) bus.in_ready[gnt] = 1'b1;
  end

  // ---- Stage p0 register: output beat, pointer and lock state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0   <= 1'b0;
      data_p0  <= '0;
      sel_p0   <= '0;
      ptr      <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
      last_p0  <= 1'b0;
      lock_act <= 1'b0;
      lock_ch  <= '0;
`endif
    end else if (load) begin
      vld_p0 <= any_gnt;
      if (any_gnt) begin
        data_p0 <= gnt_data;
        sel_p0  <= gnt;
`ifdef STREAM_MUX_PKT_LOCK_EN
        last_p0 <= gnt_last;
        if (gnt_last) begin
          lock_act <= 1'b0;
          ptr      <= ptr_nxt;
        end else begin
          lock_act <= 1'b1;
          lock_ch  <= gnt;
        end
`else
        ptr     <= ptr_nxt;
`endif
      end
    end
  end

  assign bus.out_valid = vld_p0;
  assign bus.out_data  = data_p0;
  assign bus.out_sel   = sel_p0;
`ifdef STREAM_MUX_PKT_LOCK_EN
  assign bus.out_last  = last_p0;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;
  localparam int W  = 4;
  localparam int N  = 4;
  localparam int W3 = 8;
  localparam int N3 = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stream_mux_rr_if #(.W(W),  .N(N))  bus  ();
  stream_mux_rr_if #(.W(W3), .N(N3)) bus3 ();

  stream_mux_rr #(.W(W),  .N(N))  u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  stream_mux_rr #(.W(W3), .N(N3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the main instance: pointer, lock and the expected
  // registered beat, all kept as plain integers.
  int         m_ptr;
  bit         m_valid;
  logic [W-1:0] m_data;
  int         m_sel;
  bit         m_last;
  bit         m_lock;
  int         m_lch;

  function automatic int model_grant();
    if (m_lock) return bus.in_valid[m_lch] ? m_lch : -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (bus.in_valid[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_upd
    int g;
    if (!rst_n) begin
      m_ptr <= 0; m_valid <= 1'b0; m_data <= '0; m_sel <= 0;
      m_last <= 1'b0; m_lock <= 1'b0; m_lch <= 0;
    end else if (!m_valid || bus.out_ready) begin
      g = model_grant();
      if (g < 0) begin
        m_valid <= 1'b0;
      end else begin
        m_valid <= 1'b1;
        m_data  <= bus.in_data[g*W +: W];
        m_sel   <= g;
`ifdef STREAM_MUX_PKT_LOCK_EN
        m_last  <= bus.in_last[g];
        if (bus.in_last[g]) begin
          m_lock <= 1'b0;
          m_ptr  <= (g + 1) % N;
        end else begin
          m_lock <= 1'b1;
          m_lch  <= g;
        end
`else
        m_ptr   <= (g + 1) % N;
`endif
      end
    end
  end

  always @(negedge clk) begin : compare
    int g;
    logic [N-1:0] exp_rdy;
    if (rst_n === 1'b1) begin
      check("m_out_valid", bus.out_valid, m_valid);
      if (m_valid) begin
        check("m_out_data", bus.out_data, m_data);
        check("m_out_sel", bus.out_sel, m_sel);
`ifdef STREAM_MUX_PKT_LOCK_EN
        check("m_out_last", bus.out_last, m_last);
`endif
      end
      exp_rdy = '0;
      g = model_grant();
      if ((!m_valid || bus.out_ready) && g >= 0) exp_rdy[g] = 1'b1;
      check("m_in_ready", bus.in_ready, exp_rdy);
    end
  end

  logic [N-1:0] acc;
  logic [3:0]   hs_sel [5];

  initial begin
    hs_sel = '{4'd2, 4'd0, 4'd2, 4'd0, 4'd2};
    rst_n = 1'b0;
    bus.in_valid = '1; bus.in_data = 16'hDCBA; bus.out_ready = 1'b0;
    bus3.in_valid = '0; bus3.in_data = '0; bus3.out_ready = 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
    bus.in_last = '1; bus3.in_last = '1;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, 4'h0);
    check("rst_out_sel", bus.out_sel, 2'd0);
    check("rst_in_ready", bus.in_ready, 4'b0000);

    // Round robin over four valid channels.
    @(posedge clk); #1;
    rst_n = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      check("rr_valid", bus.out_valid, 1'b1);
      check("rr_sel", bus.out_sel, i % 4);
      check("rr_data", bus.out_data, 4'hA + (i % 4));
    end

    // Single channel 2.
    @(posedge clk); #1;
    bus.in_valid = 4'b0100; bus.in_data = 16'h0500;
    @(negedge clk);
    check("one_in_ready", bus.in_ready, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check("one_sel", bus.out_sel, 2'd2);
      check("one_data", bus.out_data, 4'h5);
    end

    // Back-pressure: beat (sel 1, data 7) held for three cycles.
    @(posedge clk); #1;
    bus.in_valid = 4'b0010; bus.in_data = 16'h0070;
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.in_valid = 4'b1111; bus.in_data = 16'h4321;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", bus.out_valid, 1'b1);
      check("hold_sel", bus.out_sel, 2'd1);
      check("hold_data", bus.out_data, 4'h7);
      check("hold_in_ready", bus.in_ready, 4'b0000);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("rel_in_ready", bus.in_ready, 4'b0100);
    @(posedge clk); @(negedge clk);
    check("rel_valid", bus.out_valid, 1'b1);
    check("rel_sel", bus.out_sel, 2'd2);
    check("rel_data", bus.out_data, 4'h3);

    // Asynchronous reset in the middle of a stream.
    @(posedge clk); @(negedge clk);
    check("pre_rst_valid", bus.out_valid, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", bus.out_valid, 1'b0);
    check("arst_data", bus.out_data, 4'h0);
    check("arst_sel", bus.out_sel, 2'd0);
    check("arst_in_ready", bus.in_ready, 4'b0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("post_rst_sel", bus.out_sel, 2'd0);
    check("post_rst_data", bus.out_data, 4'h1);

    // N=3 wrap: bring ptr to 2, then channels 0 and 2 alternate.
    @(posedge clk); #1;
    bus3.in_valid = 3'b010; bus3.in_data = 24'hC2B1A0;
    @(posedge clk); #1;
    bus3.in_valid = 3'b101;
    @(negedge clk);
    check("n3_first_sel", bus3.out_sel, 2'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      check("n3_sel", bus3.out_sel, hs_sel[i]);
      check("n3_data", bus3.out_data, (hs_sel[i] == 4'd2) ? 8'hC2 : 8'hA0);
    end
    @(posedge clk); #1;
    bus3.in_valid = '0;

`ifdef STREAM_MUX_PKT_LOCK_EN
    // Channel 1 packet of three beats while channel 0 waits.
    bus.in_valid = 4'b0010; bus.in_data = 16'h0010; bus.in_last = 4'b0000;
    @(posedge clk); #1;
    bus.in_valid = 4'b0011; bus.in_data = 16'h0029; bus.in_last = 4'b0001;
    @(negedge clk);
    check("pkt1_sel", bus.out_sel, 2'd1);
    check("pkt1_last", bus.out_last, 1'b0);
    @(posedge clk); #1;
    bus.in_data = 16'h0039; bus.in_last = 4'b0011;
    @(negedge clk);
    check("pkt2_sel", bus.out_sel, 2'd1);
    check("pkt2_data", bus.out_data, 4'h2);
    check("pkt2_last", bus.out_last, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 4'b0001;
    @(negedge clk);
    check("pkt3_sel", bus.out_sel, 2'd1);
    check("pkt3_data", bus.out_data, 4'h3);
    check("pkt3_last", bus.out_last, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 4'b0000;
    @(negedge clk);
    check("pkt_next_sel", bus.out_sel, 2'd0);
    check("pkt_next_data", bus.out_data, 4'h9);
`endif

    // Randomised traffic; producers hold any beat that was not accepted.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = bus.in_valid & bus.in_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] || !bus.in_valid[i]) begin
          bus.in_valid[i] = ($urandom_range(0, 9) < 6);
          bus.in_data[i*W +: W] = W'($urandom);
`ifdef STREAM_MUX_PKT_LOCK_EN
          bus.in_last[i] = ($urandom_range(0, 2) == 0);
`endif
        end
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
